// File: rtl/top_app_if.sv
// Packet-streaming handshake bundle between top_app and its sink.
// The block side uses the slave modport; the sink/driver side uses master.
interface top_app_if #(
    parameter int DATA_W = 8
) ();
    logic              i_write;
    logic              i_ready;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_done;

    modport slave (
        input  i_write,
        input  i_ready,
        output o_valid,
        output o_data,
        output o_done
    );

    modport master (
        output i_write,
        output i_ready,
        input  o_valid,
        input  o_data,
        input  o_done
    );
endinterface

// File: rtl/top_app.sv
// Streams a length-prefixed packet out of a preloaded memory over a valid/ready
// handshake. mem[0] holds the length N, and mem[1..N] hold the payload bytes.
module top_app_mem #(
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic [AW-1:0]     i_addr,
    output logic [DATA_W-1:0] o_rdata
);
    // Contents are loaded from outside the design and survive reset.
    logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];

    assign o_rdata = mem[i_addr];
endmodule

module top_app #(
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic       i_clk,
    input  logic       i_resetn,
    top_app_if.slave   bus
);
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [AW-1:0]     r_ptr;
    logic [AW-1:0]     r_len;
    logic [AW-1:0]     w_addr;
    logic [AW-1:0]     w_mem_len;
    logic [DATA_W-1:0] w_rdata;
    logic              w_xfer;

    // One read port serves both the length fetch (IDLE) and the payload reads.
    assign w_addr    = (r_state == S_IDLE) ? '0 : r_ptr;
    assign w_mem_len = AW'(w_rdata);
    assign w_xfer    = (r_state == S_SEND) && bus.i_ready;

    top_app_mem #(
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) mem_inst (
        .i_addr  (w_addr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.i_write) begin
                    w_next = (w_mem_len != '0) ? S_SEND : S_DONE;
                end
            end
            S_SEND: begin
                if (w_xfer && (r_ptr == r_len)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Length is captured once at start so later writes to mem[0] cannot disturb the packet.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_ptr <= '0;
            r_len <= '0;
        end else if ((r_state == S_IDLE) && bus.i_write) begin
            r_ptr <= AW'(1);
            r_len <= w_mem_len;
        end else if (w_xfer && (r_ptr != r_len)) begin
            r_ptr <= r_ptr + AW'(1);
        end
    end

    always_comb begin
        bus.o_valid = 1'b0;
        bus.o_data  = '0;
        bus.o_done  = 1'b0;
        case (r_state)
            S_SEND: begin
                bus.o_valid = 1'b1;
                bus.o_data  = w_rdata;
            end
            S_DONE:  bus.o_done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_top_app.sv
// Randomized bench for top_app: a queue of expected payload bytes built from a
// shadow copy of the memory image is drained as handshakes complete.
module tb_top_app;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 256;

    logic i_clk    = 1'b0;
    logic i_resetn = 1'b0;

    always #5 i_clk = ~i_clk;

    top_app_if #(.DATA_W(DATA_W)) bus ();

    top_app #(
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) dut (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ref_mem [0:MEM_DEPTH-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic load_mem(input int n, input bit ramp);
        ref_mem[0] = n;
        dut.mem_inst.mem[0] = DATA_W'(n);
        for (int k = 1; k <= n; k++) begin
            ref_mem[k] = ramp ? k : int'($urandom_range(0, 255));
            dut.mem_inst.mem[k] = DATA_W'(ref_mem[k]);
        end
    endtask

    task automatic check_idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check("idle_valid", bus.o_valid, 0);
            check("idle_data", bus.o_data, 0);
            check("idle_done", bus.o_done, 0);
            bus.i_write = 1'b0;
            @(negedge i_clk);
        end
    endtask

    // mode: 0 random ready, 1 ready held high, 2 ready toggling, 3 stall then ready
    task automatic run_packet(input int mode, input int stall, input bit poke_write,
                              input bit poke_len, input int reset_after);
        int  exp_q[$];
        int  n;
        int  sent;
        bit  rdy;
        bit  done_seen;
        bit  aborted;

        n = ref_mem[0];
        for (int k = 1; k <= n; k++) exp_q.push_back(ref_mem[k]);
        sent      = 0;
        done_seen = 1'b0;
        aborted   = 1'b0;

        @(negedge i_clk);
        bus.i_write = 1'b1;
        @(negedge i_clk);
        bus.i_write = 1'b0;
        if (poke_len) dut.mem_inst.mem[0] = DATA_W'($urandom_range(1, 255));

        for (int cyc = 0; cyc < 4 * n + 20 && !done_seen && !aborted; cyc++) begin
            if (exp_q.size() != 0) begin
                check("valid", bus.o_valid, 1);
                check("data", bus.o_data, exp_q[0]);
                check("done_early", bus.o_done, 0);
                case (mode)
                    0:       rdy = 1'($urandom_range(0, 1));
                    1:       rdy = 1'b1;
                    2:       rdy = (cyc % 2) == 1;
                    default: rdy = (cyc >= stall);
                endcase
                bus.i_ready = rdy;
                bus.i_write = poke_write && (cyc == 3);
                if (rdy) begin
                    void'(exp_q.pop_front());
                    sent++;
                end
                if (reset_after > 0 && sent == reset_after) begin
                    @(posedge i_clk);
                    #2;
                    i_resetn = 1'b0;
                    #1;
                    check("rst_valid", bus.o_valid, 0);
                    check("rst_data", bus.o_data, 0);
                    check("rst_done", bus.o_done, 0);
                    bus.i_write = 1'b0;
                    bus.i_ready = 1'b1;
                    @(negedge i_clk);
                    i_resetn = 1'b1;
                    aborted = 1'b1;
                end
            end else begin
                check("done_pulse", bus.o_done, 1);
                check("done_valid", bus.o_valid, 0);
                check("done_data", bus.o_data, 0);
                if (mode == 1) check("cycles_to_done", cyc, n);
                done_seen   = 1'b1;
                bus.i_write = poke_write;
                bus.i_ready = 1'($urandom_range(0, 1));
            end
            if (!aborted) @(negedge i_clk);
        end
        if (!done_seen && !aborted) check("timeout", 0, 1);
        check_idle(3);
    endtask

    initial begin
        bus.i_write = 1'b0;
        bus.i_ready = 1'b0;
        #1;
        check("reset_valid", bus.o_valid, 0);
        check("reset_data", bus.o_data, 0);
        check("reset_done", bus.o_done, 0);
        #11;
        i_resetn = 1'b1;

        load_mem(120, 1'b1);
        run_packet(2, 0, 1'b0, 1'b0, 0);
        load_mem(120, 1'b1);
        run_packet(1, 0, 1'b0, 1'b0, 0);

        load_mem(0, 1'b0);
        run_packet(1, 0, 1'b0, 1'b0, 0);

        load_mem(3, 1'b0);
        run_packet(3, 5, 1'b0, 1'b0, 0);

        load_mem(120, 1'b1);
        run_packet(1, 0, 1'b0, 1'b0, 50);
        load_mem(120, 1'b1);
        run_packet(1, 0, 1'b0, 1'b0, 0);

        load_mem(20, 1'b0);
        run_packet(0, 0, 1'b1, 1'b0, 0);

        for (int t = 0; t < 4; t++) begin
            load_mem(int'($urandom_range(6, 40)), 1'b0);
            run_packet(0, 0, 1'($urandom_range(0, 1)), 1'b1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
